// File: rtl/trace_capture.sv
// trace_capture: triggered audio oscilloscope that captures 160 decimated samples and redraws them on a 160x120 VGA frame.
module trace_capture #(
  parameter int HOLDOFF_CYCLES = 1048576,
  parameter int TRIG_TIMEOUT = 1024,
  parameter logic [2:0] TRACE_COLOUR = 3'b010
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        sample_valid,
  input  logic [31:0] sample_data,
  output logic        sample_read,
  input  logic [2:0]  timebase,
  input  logic [2:0]  vscale,
  input  logic        trig_enable,
  output logic [7:0]  vga_x,
  output logic [6:0]  vga_y,
  output logic [2:0]  vga_colour,
  output logic        vga_plot,
  output logic        busy
);
  typedef enum logic [2:0] {ARM, WAIT_TRIG, CAPTURE, ERASE, PLOT, HOLDOFF} state_t;
  localparam int TW = $clog2(TRIG_TIMEOUT + 1);
  localparam int HW = $clog2(HOLDOFF_CYCLES + 1);
  state_t state, state_nxt;
  logic [15:0] s_reg;
  logic [7:0] dcnt, idx, x;
  logic [2:0] tb_reg;
  logic [TW-1:0] tcnt;
  logic [HW-1:0] hcnt;
  logic prev_neg, have_prev, first;
  logic [6:0] cap_buf [0:159];
  logic [6:0] disp_buf [0:159];
  logic dec, trig, store, unused_low;
  logic signed [15:0] t;
  logic signed [16:0] yd;
  logic [6:0] y;
  assign unused_low = ^sample_data[15:0];
  // sample_read high marks the cycle in which s_reg holds a freshly popped sample
  always_comb begin
    dec = sample_read && dcnt == 8'd0;
    trig = dec && (!trig_enable || (have_prev && prev_neg && !s_reg[15]) || tcnt == TW'(TRIG_TIMEOUT));
    store = (state == WAIT_TRIG && trig) || (state == CAPTURE && dec);
    t = $signed(s_reg) >>> (4'd10 - {1'b0, vscale});
    yd = 17'sd60 - $signed({t[15], t});
    y = yd[16] ? 7'd0 : yd > 17'sd119 ? 7'd119 : yd[6:0];
  end
  always_comb begin
    state_nxt = state;
    case (state)
      ARM:       state_nxt = WAIT_TRIG;
      WAIT_TRIG: state_nxt = trig ? CAPTURE : WAIT_TRIG;
      CAPTURE:   state_nxt = dec && idx == 8'd159 ? ERASE : CAPTURE;
      ERASE:     state_nxt = PLOT;
      PLOT:      state_nxt = x == 8'd159 ? HOLDOFF : ERASE;
      HOLDOFF:   state_nxt = hcnt == HW'(HOLDOFF_CYCLES - 1) ? ARM : HOLDOFF;
      default:   state_nxt = ARM;
    endcase
  end
  always_comb begin
    busy = state != WAIT_TRIG;
    vga_plot = state == PLOT || (state == ERASE && !first);
    vga_x = (state == ERASE || state == PLOT) ? x : 8'd0;
    vga_y = state == ERASE ? disp_buf[x] : state == PLOT ? cap_buf[x] : 7'd0;
    vga_colour = state == PLOT ? TRACE_COLOUR : 3'b000;
  end
  always_ff @(posedge clk or posedge reset)
    if (reset) state <= ARM;
    else state <= state_nxt;
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sample_read <= 1'b0;
      s_reg <= '0;
      dcnt <= '0;
      idx <= '0;
      x <= '0;
      tb_reg <= '0;
      tcnt <= '0;
      hcnt <= '0;
      prev_neg <= 1'b0;
      have_prev <= 1'b0;
      first <= 1'b1;
    end else begin
      sample_read <= sample_valid && !sample_read;
      if (sample_valid && !sample_read) s_reg <= sample_data[31:16];
      if (sample_read) dcnt <= (dcnt + 8'd1 == (8'd1 << tb_reg)) ? 8'd0 : dcnt + 8'd1;
      if (store) idx <= idx + 8'd1;
      case (state)
        ARM: begin
          dcnt <= '0;
          tcnt <= '0;
          idx <= '0;
          x <= '0;
          hcnt <= '0;
          have_prev <= 1'b0;
          tb_reg <= timebase;
        end
        WAIT_TRIG: if (dec && !trig) begin
          tcnt <= tcnt + 1'b1;
          have_prev <= 1'b1;
          prev_neg <= s_reg[15];
        end
        PLOT: if (x == 8'd159) first <= 1'b0;
              else x <= x + 8'd1;
        HOLDOFF: hcnt <= hcnt + 1'b1;
        default: ;
      endcase
    end
  end
  // frame buffers carry no reset; first-frame erase is masked by the first flag
  always_ff @(posedge clk) begin
    if (store) cap_buf[idx] <= y;
    if (state == PLOT) disp_buf[x] <= cap_buf[x];
  end
endmodule

// File: tb/tb_trace_capture.sv
// tb_trace_capture: directed frame-level checks of trace_capture with a modelled audio FIFO and a VGA pulse recorder.
module tb_trace_capture;
  logic clk = 1'b0, reset = 1'b1, sample_valid = 1'b1, trig_enable = 1'b1;
  logic [31:0] sample_data = '0;
  logic [2:0] timebase = 3'd2, vscale = 3'd7;
  logic sample_read, vga_plot, busy;
  logic [7:0] vga_x;
  logic [6:0] vga_y;
  logic [2:0] vga_colour;
  int checks = 0, passed = 0;
  int mode = 0, k = 0, pcnt = 0, blow = 0, rd_viol = 0;
  logic prev_sr = 1'b0;
  logic [15:0] cval = '0, sg;
  logic [7:0] px [0:4095];
  logic [6:0] py [0:4095];
  logic [2:0] pc [0:4095];
  int exp_y [0:159];
  int old_y [0:159];
  int base, b0;
  logic found;

  trace_capture #(.HOLDOFF_CYCLES(8), .TRIG_TIMEOUT(16), .TRACE_COLOUR(3'b010)) dut (
    .clk(clk), .reset(reset), .sample_valid(sample_valid), .sample_data(sample_data),
    .sample_read(sample_read), .timebase(timebase), .vscale(vscale), .trig_enable(trig_enable),
    .vga_x(vga_x), .vga_y(vga_y), .vga_colour(vga_colour), .vga_plot(vga_plot), .busy(busy));

  always #5 clk = ~clk;

  initial forever begin
    @(posedge clk);
    #2;
    if (sample_read) k++;
    sg = mode == 0 ? 16'(k - 40) : cval;
    sample_data = {sg, 16'hA5A5};
  end

  always @(negedge clk) begin
    if (vga_plot && pcnt < 4096) begin
      px[pcnt] = vga_x;
      py[pcnt] = vga_y;
      pc[pcnt] = vga_colour;
      pcnt++;
    end
    if (!busy) blow++;
    if (prev_sr && sample_read) rd_viol++;
    prev_sr = sample_read;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) passed++;
    else $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
  endtask

  task automatic step(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic wait_pulses(input string tag, input int n, output int b);
    b = pcnt;
    for (int i = 0; i < 6000 && pcnt < b + n; i++) step();
    step(2);
    chk(tag, pcnt - b, n);
  endtask

  task automatic check_frame(input string tag, input int b, input bit first);
    int errs = 0;
    for (int c = 0; c < 160; c++) begin
      int j = first ? b + c : b + 2 * c + 1;
      if (!first && (px[j-1] !== 8'(c) || pc[j-1] !== 3'b000 || py[j-1] !== 7'(old_y[c]))) errs++;
      if (px[j] !== 8'(c) || pc[j] !== 3'b010 || py[j] !== 7'(exp_y[c])) errs++;
    end
    chk(tag, errs, 0);
    for (int c = 0; c < 160; c++) old_y[c] = exp_y[c];
  endtask

  task automatic const_frame(input string tag, input int s, input logic [2:0] v, input logic te,
                             input int ey, input bit first = 1'b0);
    int b;
    mode = 1;
    cval = 16'(s);
    vscale = v;
    trig_enable = te;
    timebase = 3'd0;
    for (int c = 0; c < 160; c++) exp_y[c] = ey;
    wait_pulses({tag, "_count"}, first ? 160 : 320, b);
    check_frame({tag, "_pixels"}, b, first);
  endtask

  initial begin
    step(3);
    chk("rst_sample_read", sample_read, 0);
    chk("rst_vga_plot", vga_plot, 0);
    chk("rst_vga_x", vga_x, 0);
    chk("rst_vga_y", vga_y, 0);
    chk("rst_vga_colour", vga_colour, 0);
    chk("rst_busy", busy, 1);
    reset = 1'b0;
    step(); chk("rd_toggle_0", sample_read, 1);
    step(); chk("rd_toggle_1", sample_read, 0);
    step(); chk("rd_toggle_2", sample_read, 1);
    step(); chk("rd_toggle_3", sample_read, 0);
    for (int c = 0; c < 160; c++) exp_y[c] = (60 - c / 2) < 0 ? 0 : 60 - c / 2;
    wait_pulses("f1_ramp_count", 160, base);
    check_frame("f1_ramp_pixels", base, 1'b1);
    const_frame("f2_p1024_v0", 1024, 3'd0, 1'b0, 59);
    const_frame("f3_m2048_v0", -2048, 3'd0, 1'b0, 62);
    const_frame("f4_max_v7", 32767, 3'd7, 1'b0, 0);
    const_frame("f5_min_v7", -32768, 3'd7, 1'b0, 119);
    b0 = blow;
    const_frame("f6_timeout", 100, 3'd7, 1'b1, 48);
    chk("f6_wait_trig_cycles_33_34", (blow - b0 == 33) || (blow - b0 == 34), 1);
    mode = 1;
    cval = 16'd1024;
    vscale = 3'd0;
    trig_enable = 1'b0;
    found = 1'b0;
    for (int i = 0; i < 3000 && !found; i++) begin
      step();
      found = vga_plot && vga_colour == 3'b010 && vga_x == 8'd80;
    end
    chk("f7_reach_plot_x80", found, 1);
    #3 reset = 1'b1;
    #1;
    chk("f7_abort_plot", vga_plot, 0);
    chk("f7_abort_busy", busy, 1);
    chk("f7_abort_x", vga_x, 0);
    step(2);
    reset = 1'b0;
    const_frame("f8_after_abort", 1024, 3'd0, 1'b0, 59, 1'b1);
    chk("rd_never_consecutive", rd_viol, 0);
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule
